text_dump_tx: RTL and testbench

Streams the contents of the text-page character memory out of the board as a UART byte stream, row by row, so a host terminal can capture exactly what is on screen. It is the read-out counterpart of the switch/key text writer. It shares the character `textPage` port through the top-level address mux and reads only while the VGA controller is outside active video (`disp` low). Each screen row becomes COLS characters followed by CR LF, sent 8N1 at a fixed baud.

---
 rtl/text_pkg.sv | 33 +++
 rtl/uart_tx_byte.sv | 64 ++++++
 rtl/text_dump_tx.sv | 164 ++++++++++++++++
 tb/tb_text_dump_tx.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/text_pkg.sv
// Shared definitions for the text-page dump path.
//   TEXT_COLS / TEXT_ROWS / TEXT_ADDR_W : default page geometry and address width
//   ASCII_CR / ASCII_LF / ASCII_SUBST   : line terminators and the stand-in for unprintable bytes
//   dump_state_t                        : state encoding of the dump sequencer
//   printable_or_dot()                  : maps a character cell to the byte put on the wire
package text_pkg;

    localparam int TEXT_COLS   = 80;
    localparam int TEXT_ROWS   = 60;
    localparam int TEXT_ADDR_W = 13;

    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_SUBST = 8'h2E;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_BLANK,
        ADDR,
        READ,
        SEND,
        EOL_CR,
        EOL_LF,
        FINISH
    } dump_state_t;

    // Control codes and high-bit bytes would confuse the host terminal, so
    // only 0x20..0x7E go out as-is.
    function automatic logic [7:0] printable_or_dot(input logic [7:0] b);
        return ((b >= 8'h20) && (b <= 8'h7E)) ? b : ASCII_SUBST;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 UART transmitter for a single byte.
//   CLOCK_50 : system clock (rising edge)
//   RESET_N  : asynchronous active-low reset; line returns to idle high at once
//   load     : accept data when ready is high
//   data     : byte to send, LSB first
//   ready    : high when a new byte can be accepted
//   tx       : serial line, idle high
module uart_tx_byte #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic       load,
    input  logic [7:0] data,
    output logic       ready,
    output logic       tx
);
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    logic [BAUD_W-1:0] baud_cnt_reg;
    logic [3:0]        bit_cnt_reg;   // 0 = start bit, 1..8 = data, 9 = stop bit
    logic [8:0]        shift_reg;     // remaining data bits followed by the stop bit
    logic              active_reg;
    logic              tx_reg;
    logic              frame_last;

    assign frame_last = active_reg && (bit_cnt_reg == 4'd9) && (baud_cnt_reg == BAUD_LAST);
    // Ready is raised during the final stop-bit cycle so the caller can see
    // the frame boundary without an extra cycle of delay.
    assign ready = !active_reg || frame_last;
    assign tx    = tx_reg;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            baud_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            shift_reg    <= '1;
            active_reg   <= 1'b0;
            tx_reg       <= 1'b1;
        end else if (load && ready) begin
            shift_reg    <= {1'b1, data};
            tx_reg       <= 1'b0;
            bit_cnt_reg  <= '0;
            baud_cnt_reg <= '0;
            active_reg   <= 1'b1;
        end else if (active_reg) begin
            if (baud_cnt_reg == BAUD_LAST) begin
                baud_cnt_reg <= '0;
                if (bit_cnt_reg == 4'd9) begin
                    active_reg <= 1'b0;
                    tx_reg     <= 1'b1;
                end else begin
                    tx_reg      <= shift_reg[0];
                    shift_reg   <= {1'b1, shift_reg[8:1]};
                    bit_cnt_reg <= bit_cnt_reg + 4'd1;
                end
            end else begin
                baud_cnt_reg <= baud_cnt_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/text_dump_tx.sv
// Dumps the text page over UART, one row per line (COLS chars + CR LF).
// Memory is only touched while the display is in blanking (disp low).
//   CLOCK_50 / RESET_N : clock, asynchronous active-low reset
//   start              : one-cycle request to dump the page (ignored while busy)
//   disp               : display owns the memory when high
//   mem_req / mem_addr : claim the text-page port and the linear cell address
//   mem_q              : read data, valid the cycle after the address is sampled
//   tx                 : UART line, idle high
//   busy / done        : dump in progress / one-cycle completion pulse
module text_dump_tx
    import text_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int COLS         = TEXT_COLS,
    parameter int ROWS         = TEXT_ROWS,
    parameter int ADDR_W       = TEXT_ADDR_W
) (
    input  logic              CLOCK_50,
    input  logic              RESET_N,
    input  logic              start,
    input  logic              disp,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_q,
    output logic              tx,
    output logic              busy,
    output logic              done
);
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

    dump_state_t       state_reg;
    logic [COL_W-1:0]  col_reg;
    logic [ROW_W-1:0]  row_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic              mem_req_reg;
    logic              busy_reg;
    logic              done_reg;
    logic              launched_reg;  // CR/LF frame already handed to the UART

    logic              uart_load;
    logic [7:0]        uart_data;
    logic              uart_ready;

    assign mem_req  = mem_req_reg;
    assign mem_addr = addr_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;

    // The character byte goes straight from mem_q into the UART in READ, so
    // the first start bit follows READ with no extra staging cycle.
    always_comb begin
        uart_load = 1'b0;
        uart_data = printable_or_dot(mem_q);
        case (state_reg)
            READ:    uart_load = !disp && uart_ready;
            EOL_CR: begin
                uart_data = ASCII_CR;
                uart_load = !launched_reg && uart_ready;
            end
            EOL_LF: begin
                uart_data = ASCII_LF;
                uart_load = !launched_reg && uart_ready;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_reg    <= IDLE;
            col_reg      <= '0;
            row_reg      <= '0;
            addr_reg     <= '0;
            mem_req_reg  <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            launched_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: if (start) begin
                    col_reg   <= '0;
                    row_reg   <= '0;
                    addr_reg  <= '0;
                    busy_reg  <= 1'b1;
                    state_reg <= WAIT_BLANK;
                end
                WAIT_BLANK: if (!disp) begin
                    mem_req_reg <= 1'b1;
                    state_reg   <= ADDR;
                end
                ADDR: if (disp) begin
                    mem_req_reg <= 1'b0;
                    state_reg   <= WAIT_BLANK;
                end else begin
                    state_reg <= READ;
                end
                READ: if (disp) begin
                    // Active video began mid-read: drop the data, retry this cell.
                    mem_req_reg <= 1'b0;
                    state_reg   <= WAIT_BLANK;
                end else if (uart_ready) begin
                    mem_req_reg <= 1'b0;
                    state_reg   <= SEND;
                end
                SEND: if (uart_ready) begin
                    // Hold addr on the very last cell so it stays inside the page.
                    if (!((col_reg == COL_LAST) && (row_reg == ROW_LAST)))
                        addr_reg <= addr_reg + 1'b1;
                    if (col_reg == COL_LAST) begin
                        col_reg      <= '0;
                        launched_reg <= 1'b0;
                        state_reg    <= EOL_CR;
                    end else begin
                        col_reg   <= col_reg + 1'b1;
                        state_reg <= WAIT_BLANK;
                    end
                end
                EOL_CR: if (uart_ready) begin
                    if (!launched_reg) begin
                        launched_reg <= 1'b1;
                    end else begin
                        launched_reg <= 1'b0;
                        state_reg    <= EOL_LF;
                    end
                end
                EOL_LF: if (uart_ready) begin
                    if (!launched_reg) begin
                        launched_reg <= 1'b1;
                    end else begin
                        launched_reg <= 1'b0;
                        if (row_reg == ROW_LAST) begin
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                            state_reg <= FINISH;
                        end else begin
                            row_reg   <= row_reg + 1'b1;
                            state_reg <= WAIT_BLANK;
                        end
                    end
                end
                FINISH: begin
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart (
        .CLOCK_50(CLOCK_50),
        .RESET_N (RESET_N),
        .load    (uart_load),
        .data    (uart_data),
        .ready   (uart_ready),
        .tx      (tx)
    );

endmodule

// File: tb/tb_text_dump_tx.sv
// Bench for text_dump_tx on a 4x2 page at 4 clocks per bit. A line monitor
// decodes every UART frame; dumps are compared against byte streams built
// from the page contents.
module tb_text_dump_tx;
    localparam int CPB   = 4;
    localparam int COLS  = 4;
    localparam int ROWS  = 2;
    localparam int NCELL = COLS * ROWS;
    localparam int NBYTE = ROWS * (COLS + 2);
    localparam int FRAME = 10 * CPB;
    localparam int DUMP_LIMIT = 8000;

    typedef logic [7:0] byte_q_t[$];
    typedef struct packed {
        logic [63:0] cells;   // cell 0 in the top byte
        logic [95:0] exp;     // first expected byte in the top byte
    } vec_t;

    logic        CLOCK_50 = 1'b0;
    logic        RESET_N  = 1'b0;
    logic        start    = 1'b0;
    logic        disp     = 1'b0;
    logic        mem_req;
    logic [12:0] mem_addr;
    logic [7:0]  mem_q = 8'h00;
    logic        tx, busy, done;

    int tests = 0;
    int fails = 0;

    always #5 CLOCK_50 = ~CLOCK_50;

    text_dump_tx #(.CLKS_PER_BIT(CPB), .COLS(COLS), .ROWS(ROWS), .ADDR_W(13)) dut (
        .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .start(start), .disp(disp),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_q(mem_q),
        .tx(tx), .busy(busy), .done(done)
    );

    // Text page behind the top-level mux: data from a cycle where the dumper
    // did not own the port (or disp was high) is junk.
    logic [7:0] mem [NCELL];
    always @(posedge CLOCK_50)
        mem_q <= (mem_req && !disp && (mem_addr < 13'(NCELL))) ? mem[mem_addr[2:0]] : 8'h01;

    // disp driver: manual level or random runs of blanking/active video.
    bit   rand_disp   = 0;
    logic disp_manual = 1'b0;
    logic disp_rval   = 1'b0;
    int   disp_run    = 0;
    always begin
        @(posedge CLOCK_50);
        #2;
        if (rand_disp) begin
            if (disp_run == 0) begin
                disp_rval = ~disp_rval;
                disp_run  = disp_rval ? int'($urandom_range(1, 40)) : int'($urandom_range(1, 25));
            end
            disp_run--;
            disp = disp_rval;
        end else begin
            disp = disp_manual;
        end
    end

    // Line monitor, sampled on the falling clock edge.
    byte_q_t rx_q;
    int   cyc = 0, idx = 0, frames_done = 0, last_end_cyc = -10;
    int   guard_viol = 0, addr_oob = 0, reads2 = 0;
    logic in_frame = 1'b0, prev_both = 1'b0, prev_req = 1'b0;
    logic [FRAME-1:0] samp;

    always @(negedge CLOCK_50) begin
        cyc++;
        if (!RESET_N) begin
            in_frame  = 1'b0;
            idx       = 0;
            prev_both = 1'b0;
            prev_req  = 1'b0;
        end else begin
            if (!in_frame) begin
                if (tx == 1'b0) begin
                    in_frame = 1'b1;
                    samp[0]  = 1'b0;
                    idx      = 1;
                end
            end else begin
                samp[idx] = tx;
                idx++;
                if (idx == FRAME) begin
                    bit ok;
                    logic [7:0] b;
                    ok = 1;
                    for (int bi = 0; bi < 10; bi++)
                        for (int s = 1; s < CPB; s++)
                            if (samp[bi*CPB+s] !== samp[bi*CPB]) ok = 0;
                    if (samp[9*CPB] !== 1'b1) ok = 0;
                    for (int d = 0; d < 8; d++) b[d] = samp[(d+1)*CPB];
                    tests++;
                    if (!ok) begin
                        fails++;
                        $display("FAIL frame_shape: got samples %b (first sample rightmost), required %0d-cycle bits, start 0, stop 1", samp, CPB);
                    end
                    rx_q.push_back(b);
                    frames_done++;
                    last_end_cyc = cyc;
                    in_frame = 1'b0;
                end
            end
            if (done) begin
                tests++;
                if (cyc != last_end_cyc + 1) begin
                    fails++;
                    $display("FAIL done_timing: done at cycle %0d, required %0d (right after LF stop bit)", cyc, last_end_cyc + 1);
                end
            end
            if (mem_req && disp && prev_both) guard_viol++;
            prev_both = mem_req && disp;
            if (mem_req && (mem_addr >= 13'(NCELL))) addr_oob++;
            if (mem_req && !prev_req && (mem_addr == 13'd2)) reads2++;
            prev_req = mem_req;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic check_stream(input string name, input byte_q_t exp);
        check({name, "_len"}, rx_q.size(), exp.size());
        for (int i = 0; i < exp.size() && i < rx_q.size(); i++)
            check($sformatf("%s_byte%0d", name, i), int'(rx_q[i]), int'(exp[i]));
    endtask

    // Expected wire stream computed from the page contents.
    function automatic byte_q_t ref_stream();
        byte_q_t q;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                logic [7:0] v;
                v = mem[r*COLS+c];
                q.push_back((v >= 8'h20 && v <= 8'h7E) ? v : 8'h2E);
            end
            q.push_back(8'h0D);
            q.push_back(8'h0A);
        end
        return q;
    endfunction

    function automatic byte_q_t vec_stream(input vec_t v);
        byte_q_t q;
        for (int i = 0; i < NBYTE; i++) q.push_back(v.exp[95-8*i -: 8]);
        return q;
    endfunction

    task automatic load_vec(input vec_t v);
        for (int i = 0; i < NCELL; i++) mem[i] = v.cells[63-8*i -: 8];
    endtask

    task automatic pulse_start();
        @(posedge CLOCK_50); #2 start = 1'b1;
        @(posedge CLOCK_50); #2 start = 1'b0;
    endtask

    // Runs one dump to completion. extra_start: loop cycle at which a second
    // start is pulsed (-1 none). disp_cell: cell whose READ gets interrupted
    // by 50 cycles of active video (-1 none).
    task automatic do_dump(input bit chk_lat, input int extra_start, input int disp_cell);
        int n, busy_lows, extra_dones, fired_n;
        bit fired;
        logic prev_r;
        n = 0; busy_lows = 0; extra_dones = 0; fired = 0; fired_n = 0; prev_r = 1'b0;
        rx_q.delete();
        pulse_start();
        if (chk_lat) begin
            @(negedge CLOCK_50);
            check("busy_after_start", busy, 1);
            check("tx_idle_wait_blank", tx, 1);
            @(negedge CLOCK_50); check("tx_idle_addr", tx, 1);
            @(negedge CLOCK_50); check("tx_idle_read", tx, 1);
            @(negedge CLOCK_50); check("first_start_bit", tx, 0);
        end
        while (!done && n < DUMP_LIMIT) begin
            @(negedge CLOCK_50);
            n++;
            if (!done && !busy) busy_lows++;
            start = (n == extra_start);
            if (disp_cell >= 0 && !fired && mem_req && !prev_r && mem_addr == 13'(disp_cell)) begin
                disp_manual = 1'b1;
                fired   = 1;
                fired_n = n;
            end
            if (fired && n == fired_n + 50) disp_manual = 1'b0;
            prev_r = mem_req;
        end
        start = 1'b0;
        disp_manual = 1'b0;
        check("dump_completes", done, 1);
        check("busy_low_at_done", busy, 0);
        check("busy_high_during_dump_lows", busy_lows, 0);
        repeat (6) begin
            @(negedge CLOCK_50);
            if (done) extra_dones++;
        end
        check("extra_done_pulses", extra_dones, 0);
        check("busy_idle_after", busy, 0);
    endtask

    vec_t vecs[3];

    initial begin
        vecs[0] = '{cells: 64'h41424344_7778797A, exp: 96'h41424344_0D0A7778_797A0D0A};
        vecs[1] = '{cells: 64'h007F1B20_7E21FF80, exp: 96'h2E2E2E20_0D0A7E21_2E2E0D0A};
        vecs[2] = '{cells: 64'h1F5A6130_0A0D7D3F, exp: 96'h2E5A6130_0D0A2E2E_7D3F0D0A};

        // Reset values
        repeat (3) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_addr", int'(mem_addr), 0);
        @(posedge CLOCK_50); #2 RESET_N = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        check("idle_tx", tx, 1);
        check("idle_busy", busy, 0);

        // Table-driven dumps with disp held low
        for (int v = 0; v < 3; v++) begin
            load_vec(vecs[v]);
            do_dump(v == 0, -1, -1);
            check_stream($sformatf("vec%0d", v), vec_stream(vecs[v]));
        end

        // Active video interrupts the READ of cell 2
        load_vec(vecs[0]);
        guard_viol = 0;
        reads2 = 0;
        do_dump(0, -1, 2);
        check_stream("disp_retry", vec_stream(vecs[0]));
        check("cell2_read_attempts", reads2, 2);
        check("mem_req_while_disp", guard_viol, 0);

        // Second start mid-dump is ignored
        do_dump(0, 100, -1);
        check_stream("restart_ignored", vec_stream(vecs[0]));

        // Reset during the third frame, then a clean restart from cell 0
        begin
            int n, base;
            n = 0;
            base = frames_done;
            rx_q.delete();
            pulse_start();
            while (!(frames_done >= base + 2 && in_frame) && n < DUMP_LIMIT) begin
                @(negedge CLOCK_50);
                n++;
            end
            check("third_frame_reached", int'(in_frame), 1);
            repeat (10) @(negedge CLOCK_50);
            @(posedge CLOCK_50); #3 RESET_N = 1'b0;
            #1;
            check("async_rst_tx", tx, 1);
            check("async_rst_busy", busy, 0);
            check("async_rst_mem_req", mem_req, 0);
            check("pre_reset_bytes", rx_q.size(), 2);
            repeat (2) @(negedge CLOCK_50);
            @(posedge CLOCK_50); #2 RESET_N = 1'b1;
            repeat (2) @(negedge CLOCK_50);
            do_dump(0, -1, -1);
            check_stream("after_reset", vec_stream(vecs[0]));
        end

        // Random page contents under random blanking
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < NCELL; i++) mem[i] = 8'($urandom_range(0, 255));
            rand_disp = 1;
            do_dump(0, -1, -1);
            rand_disp = 0;
            check_stream($sformatf("rand%0d", t), ref_stream());
        end

        check("mem_req_guard_total", guard_viol, 0);
        check("addr_in_range", addr_oob, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
